// File: rtl/apb_slave_pkg.sv
// Shared types, constants and helpers for the APB completer memory.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } apb_slv_state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int STRB_SIZE      = DATA_WIDTH_DEF / 8;
  localparam logic [STRB_SIZE-1:0] FULL_STRB = '1;

  // True when a word address falls outside the RAM. The caller zero-extends
  // the full bus address so high address bits take part in the compare.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/apb_ram_bank.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
module apb_ram_bank #(
  parameter int  DATA_WIDTH = 32,
  parameter int  MEM_DEPTH  = 256,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [STRB_W-1:0]     be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-lane writes and read-first registered read of the addressed word.
  // NOTE: the array has no reset; clearing a RAM needs a per-word sweep, and
  // contents are meant to survive a bus reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (be[i]) begin
          mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer in front of a word-addressed RAM: phase decode, programmable
// wait states, byte-strobed writes, full-word reads and PSLVERR decode.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // pready is registered, so completion is decided one edge before the pready
  // cycle. The setup edge accounts for one wait state, hence the minus one.
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  apb_slv_state_t state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  rd_ok_q, rd_ok_d;

  logic                  capture, complete, live_err, cur_wr, cur_err;
  logic                  ram_we;
  logic [STRB_W-1:0]     ram_be;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  // Next-state, latch, wait-count and completion decode.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    rd_ok_d   = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    live_err  = addr_err(64'(paddr), 64'(MEM_DEPTH)) || (pwrite && (pstrb == '0));

    case (state_q)
      IDLE, DONE: begin
        // penable without psel is a protocol violation and is simply ignored.
        if (psel && !penable) capture = 1'b1;
        else                  state_d = IDLE;
      end
      SETUP: begin
        if (!psel)                state_d = IDLE;
        else if (!penable)        capture = 1'b1;
        else if (cnt_q == 4'd0)   complete = 1'b1;
        else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel)                state_d = IDLE;
        else if (cnt_q == 4'd0)   complete = 1'b1;
        else                      cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      addr_d  = paddr[IDX_W-1:0];
      wr_d    = pwrite;
      wdata_d = pwdata;
      strb_d  = pstrb;
      err_d   = live_err;
      cnt_d   = WAIT_LOAD;
      // With no wait states the setup edge itself must complete the transfer.
      if (ZERO_WAIT) complete = 1'b1;
      else           state_d  = SETUP;
    end

    // A transfer completing on its own setup edge uses the live bus values.
    cur_wr  = capture ? pwrite   : wr_q;
    cur_err = capture ? live_err : err_q;

    if (complete) begin
      state_d   = DONE;
      pready_d  = 1'b1;
      pslverr_d = cur_err;
      rd_ok_d   = !cur_wr && !cur_err;
    end

    ram_addr  = capture ? paddr[IDX_W-1:0] : addr_q;
    ram_be    = capture ? pstrb  : strb_q;
    ram_wdata = capture ? pwdata : wdata_q;
    ram_we    = complete && cur_wr && !cur_err && !rst;
  end

  // Control state and registered outputs, cleared by synchronous reset.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  // Latched transfer attributes; only meaningful while a transfer is open.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
    err_q   <= err_d;
  end

  apb_ram_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register is updated on the completion edge; the registered
  // read-valid flag zeroes it outside a successful read's pready cycle.
  assign prdata  = rd_ok_q ? ram_rdata : '0;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with one wait state and one
// with three, sharing the bus apart from psel.
module tb_apb_slave_mem;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          psel_a, psel_b, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] prdata_a, prdata_b;
  logic          pready_a, pready_b, pslverr_a, pslverr_b;

  int n_checks = 0;
  int n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_STATES(1)) dut_a (
    .clk(clk), .rst(rst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_slave_mem #(.WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer: setup at the next negedge, then access until pready.
  // cycles counts bus cycles from setup (1) to the pready cycle inclusive.
  task automatic xfer(input bit on_b, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int cycles);
    logic rdy;
    @(negedge clk);
    psel_a  = !on_b;
    psel_b  = on_b;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    cycles  = 1;
    @(negedge clk);
    penable = 1'b1;
    cycles  = 2;
    forever begin
      rdy = on_b ? pready_b : pready_a;
      if (rdy || cycles >= 40) break;
      check("wait_quiet", 64'(on_b ? {pslverr_b, prdata_b} : {pslverr_a, prdata_a}), '0);
      @(negedge clk);
      cycles++;
    end
    check("no_timeout", 64'(rdy), 64'd1);
    rdata = on_b ? prdata_b : prdata_a;
    err   = on_b ? pslverr_b : pslverr_a;
  endtask

  task automatic do_write(input bit on_b, input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    xfer(on_b, 1'b1, addr, data, strb, rd, er, cyc);
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_lat"}, 64'(cyc), on_b ? 64'd5 : 64'd3);
  endtask

  task automatic do_read(input bit on_b, input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    xfer(on_b, 1'b0, addr, 32'h0, 4'h0, rd, er, cyc);
    check({tag, "_data"}, 64'(rd), 64'(exp_data));
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_lat"}, 64'(cyc), on_b ? 64'd5 : 64'd3);
  endtask

  // Release the bus; the cycle after a pready pulse must be fully quiet.
  task automatic idle();
    @(negedge clk);
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    check("done_clears_a", 64'({pready_a, pslverr_a, prdata_a}), '0);
    check("done_clears_b", 64'({pready_b, pslverr_b, prdata_b}), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_a", 64'({pready_a, pslverr_a, prdata_a}), '0);
    check("reset_b", 64'({pready_b, pslverr_b, prdata_b}), '0);
    rst = 1'b0;

    // Basic write/read with one wait state: pready two cycles after setup.
    do_write(0, "basic_wr", 32'hF0, 32'h000A_3210, 4'hF, 1'b0);
    do_read (0, "basic_rd", 32'hF0, 32'h000A_3210, 1'b0);
    idle();

    // Partial byte-lane writes.
    do_write(0, "strb3_pre", 32'h12, 32'hFFFF_FFFF, 4'hF, 1'b0);
    do_write(0, "strb3_wr",  32'h12, 32'h510F_CB29, 4'h3, 1'b0);
    do_read (0, "strb3_rd",  32'h12, 32'hFFFF_CB29, 1'b0);
    do_write(0, "strb4_pre", 32'h3D, 32'h0000_0000, 4'hF, 1'b0);
    do_write(0, "strb4_wr",  32'h3D, 32'h0102_1034, 4'h4, 1'b0);
    do_read (0, "strb4_rd",  32'h3D, 32'h0002_0000, 1'b0);
    idle();

    // Error responses: out of range (no aliasing onto word 0), high address
    // bits, last legal word, and a null-strobe write.
    do_write(0, "oor_pre0",  32'h00,        32'h1357_2468, 4'hF, 1'b0);
    do_write(0, "oor_wr",    32'h100,       32'hAAAA_AAAA, 4'hF, 1'b1);
    do_read (0, "oor_rd",    32'h100,       32'h0000_0000, 1'b1);
    do_read (0, "oor_alias", 32'h00,        32'h1357_2468, 1'b0);
    do_write(0, "hi_addr",   32'h8000_0010, 32'hBBBB_BBBB, 4'hF, 1'b1);
    do_write(0, "last_wr",   32'hFF,        32'h0F0F_0F0F, 4'hF, 1'b0);
    do_read (0, "last_rd",   32'hFF,        32'h0F0F_0F0F, 1'b0);
    do_write(0, "null_pre",  32'h10,        32'h5A5A_5A5A, 4'hF, 1'b0);
    do_write(0, "null_wr",   32'h10,        32'h1234_5678, 4'h0, 1'b1);
    do_read (0, "null_rd",   32'h10,        32'h5A5A_5A5A, 1'b0);
    do_read (0, "hi_alias",  32'h10,        32'h5A5A_5A5A, 1'b0);
    idle();

    // Back-to-back bursts with no idle cycle between transfers.
    for (int i = 0; i < 8; i++)
      do_write(0, "b2b_wr", 32'hB0 + 32'(i), 32'hC0D9_42F0 + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 8; i++)
      do_read(0, "b2b_rd", 32'hB0 + 32'(i), 32'hC0D9_42F0 + 32'(i), 1'b0);
    idle();

    // Three wait states: latency five cycles from setup.
    do_write(1, "ws3_wr", 32'h20, 32'h7777_8888, 4'hF, 1'b0);
    do_read (1, "ws3_rd", 32'h20, 32'h7777_8888, 1'b0);
    idle();

    // psel dropped while in ACCESS: no response and no RAM write.
    @(negedge clk);
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h20; pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("abandon_wait", 64'(pready_b), '0);
    psel_b  = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abandon_quiet", 64'({pready_b, pslverr_b}), '0);
    end
    do_read(1, "abandon_rd", 32'h20, 32'h7777_8888, 1'b0);
    idle();

    // penable without psel in IDLE is ignored.
    @(negedge clk);
    penable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_penable", 64'({pready_a, pslverr_a, prdata_a}), '0);
    end
    penable = 1'b0;

    // Reset held for three edges while a write is in ACCESS aborts it.
    do_write(1, "rstw_pre", 32'h40, 32'h1111_2222, 4'hF, 1'b0);
    idle();
    @(negedge clk);
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h40; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_outs", 64'({pready_b, pslverr_b, prdata_b}), '0);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_quiet", 64'(pready_b), '0);
    end
    do_read(1, "rstw_rd", 32'h40, 32'h1111_2222, 1'b0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer: the responder end of the APB master bus driven by the bridge.
- Decodes APB setup/access phases and inserts a programmable number of wait states.
- Performs byte-strobed writes and full-word reads on an internal word-addressed RAM.
- Signals PSLVERR for out-of-range addresses and null-strobe writes; replaces the passive memory model behind the bridge's completer port.

Parameters:
ADDR_WIDTH, 32, APB address width; word index, no byte offset
DATA_WIDTH, 32, APB data width; multiple of 8
MEM_DEPTH, 256, number of RAM words; legal paddr range 0..MEM_DEPTH-1
WAIT_STATES, 1, access-phase cycles with pready=0 before completion (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
psel  input  1  completer select
penable  input  1  access phase indicator
pwrite  input  1  1=write, 0=read
paddr  input  ADDR_WIDTH  word address
pwdata  input  DATA_WIDTH  write data
pstrb  input  DATA_WIDTH/8  write byte-lane enables (ignored on read)
prdata  output  DATA_WIDTH  read data, valid only when pready=1
pready  output  1  transfer completion
pslverr  output  1  error response, valid only when pready=1

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE and the wait counter clears.
  - pready=0, pslverr=0, prdata=0.
  - RAM contents are not cleared.
  - A transfer in flight is aborted with no RAM write.
- Outputs are all registered.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE -> SETUP when psel=1 and penable=0.
  - On this edge, latch paddr, pwrite, pwdata, pstrb.
  - Load the wait counter with WAIT_STATES.
  - Compute err = (paddr >= MEM_DEPTH) or (pwrite and pstrb==0).
- SETUP -> ACCESS when psel=1 and penable=1.
  - psel=0 -> IDLE (abandoned, no effect).
  - penable=0 with psel=1 -> stay in SETUP and re-latch.
- ACCESS:
  - While counter != 0: decrement, pready stays 0.
  - When counter == 0: next edge registers pready=1 and pslverr=err.
    - Read without err: prdata = ram[addr].
    - Read with err: prdata = 0.
    - Write without err: RAM commits byte lanes where pstrb[i]=1 on that same edge.
    - Write with err: RAM unchanged.
  - Goes to DONE.
- Latency: setup at cycle T0, first access cycle T1, pready=1 during cycle T1+WAIT_STATES.
  - WAIT_STATES=0 gives zero-wait APB (pready in T1).
- DONE (the pready=1 cycle): the next edge clears pready, pslverr and prdata to 0.
  - psel=1 and penable=0 -> SETUP with new latch (back-to-back transfer).
  - Otherwise -> IDLE.
- psel dropping in ACCESS before completion -> IDLE.
  - pready never asserts and no RAM write occurs.
- penable=1 in IDLE (protocol violation) is ignored; stay in IDLE.
- paddr, pwdata and pstrb changes during ACCESS are ignored; latched values are used.
- prdata holds 0 outside the pready cycle; pslverr is never 1 while pready=0.
- Address compare uses the full ADDR_WIDTH.
- RAM index is the low clog2(MEM_DEPTH) bits after the range check passes.

Decomposition:
- Package apb_slave_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_slv_state_t.
  - STRB_SIZE = DATA_WIDTH/8.
  - Constant FULL_STRB = all ones.
  - Function addr_err(addr, depth).
- Sub-module apb_ram_bank: single-port synchronous RAM with per-byte write enable and registered read. It is parameterised by DATA_WIDTH and MEM_DEPTH and has ports clk, we, be, addr, wdata, rdata.
- apb_slave_mem holds the FSM, wait counter, error decode and output registers.

Test Plan:
1. rst=1 for 3 cycles mid-write (in ACCESS) -> pready/pslverr/prdata=0 next edge. A later read of that address returns its old value.
2. WAIT_STATES=1: write paddr=0xF0, pwdata=0x000A3210, pstrb=4'hF, then read 0xF0 -> pready high exactly 2 cycles after setup, pslverr=0, prdata=0x000A3210.
3. Write 0x12 with pstrb=4'h3, data 0x510FCB29, over prior content 0xFFFFFFFF -> read returns 0xFFFFCB29. pstrb=4'h4, data 0x01021034 on 0x3D over 0 -> read returns 0x00020000.
4. Write and read at paddr=0x100 (MEM_DEPTH=256) -> pready with pslverr=1, prdata=0. Write with pstrb=0 at 0x10 -> pslverr=1, RAM unchanged.
5. Back-to-back: 8 writes to 0xB0..0xB7 with data 0xC0D942F0+i, setup immediately after each DONE, then 8 reads -> each completes in WAIT_STATES+2 cycles with matching data, no idle cycle inserted.
6. psel deasserted in ACCESS before pready on a write to 0x20 -> no pready pulse, RAM[0x20] unchanged. penable=1 with psel=0 in IDLE -> no response.
